memory_responder: RTL and testbench

- Word-organised memory target that answers the ARMv4 core's memory request interface (cs/we/oe/address/ram_data_in) and returns read data and a ready handshake (ram_data_out/ram_ready).
- Sits outside the core on the same bus, in place of the external RAM.
- Models a configurable number of wait states so the core's mem_ready-driven states are exercised.
- Flags misaligned and out-of-range accesses.

---
 rtl/memory_responder.sv | 147 ++++++++++++++
 tb/tb_memory_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Purpose  : Word-organised RAM target for the core's memory bus, with
//            configurable wait states and misaligned/out-of-range flagging.
// Revision : 1.0 - initial release
// ============================================================================
module memory_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic        oe,
    input  logic [31:0] address,
    input  logic [31:0] ram_data_in,
    output logic [31:0] ram_data_out,
    output logic        ram_ready,
    output logic        err
);
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    write_q;
    logic                    bad_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    w_req;
    logic [31:0]             w_offset;
    logic                    w_out_of_range;
    logic                    w_bad;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [1:0]              w_unused_offset;
    logic                    w_go_resp;
    logic                    w_commit;
    logic                    w_src_write;
    logic                    w_src_bad;
    logic [ADDR_WIDTH-1:0]   w_src_idx;
    logic [31:0]             w_src_data;

    assign w_req           = cs & (we | oe);
    assign w_offset        = address - BASE_ADDR;
    assign w_idx           = w_offset[ADDR_WIDTH+1:2];
    assign w_unused_offset = w_offset[1:0];

    // Subtraction wraps, so addresses below BASE_ADDR land in the high bits too.
    generate
        if (ADDR_WIDTH < 30) begin : g_range_chk
            assign w_out_of_range = |w_offset[31:ADDR_WIDTH+2];
        end else begin : g_range_full
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_bad = (|address[1:0]) | w_out_of_range;

    // With zero wait states the commit edge is also the accept edge, so the
    // live bus values must be used instead of the not-yet-latched copies.
    assign w_src_write = (state_q == ST_IDLE) ? we          : write_q;
    assign w_src_bad   = (state_q == ST_IDLE) ? w_bad       : bad_q;
    assign w_src_idx   = (state_q == ST_IDLE) ? w_idx       : idx_q;
    assign w_src_data  = (state_q == ST_IDLE) ? ram_data_in : wdata_q;
    assign w_commit    = w_go_resp & ~rst;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_go_resp = 1'b0;
        ram_ready = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_RESP;
                        w_go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = ST_RESP;
                    w_go_resp = 1'b1;
                end
            end
            ST_RESP: begin
                ram_ready = 1'b1;
                err       = bad_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && w_req) begin
                write_q <= we;
                bad_q   <= w_bad;
                idx_q   <= w_idx;
                wdata_q <= ram_data_in;
            end
            if (w_commit && !w_src_write) begin
                rdata_q <= w_src_bad ? 32'h0 : mem_q[w_src_idx];
            end
        end
    end

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_commit && w_src_write && !w_src_bad) begin
            mem_q[w_src_idx] <= w_src_data;
        end
    end

    assign ram_data_out = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_responder
// Purpose  : Directed self-checking bench; instance 0 uses two wait states,
//            instance 1 uses zero wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        cs_a   [2];
    logic        we_a   [2];
    logic        oe_a   [2];
    logic [31:0] addr_a [2];
    logic [31:0] wd_a   [2];
    logic [31:0] rd_a   [2];
    logic        rdy_a  [2];
    logic        er_a   [2];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_dut2 (
        .clk(clk), .rst(rst), .cs(cs_a[0]), .we(we_a[0]), .oe(oe_a[0]),
        .address(addr_a[0]), .ram_data_in(wd_a[0]), .ram_data_out(rd_a[0]),
        .ram_ready(rdy_a[0]), .err(er_a[0])
    );

    memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst(rst), .cs(cs_a[1]), .we(we_a[1]), .oe(oe_a[1]),
        .address(addr_a[1]), .ram_data_in(wd_a[1]), .ram_data_out(rd_a[1]),
        .ram_ready(rdy_a[1]), .err(er_a[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus(input int d);
        cs_a[d] = 1'b0; we_a[d] = 1'b0; oe_a[d] = 1'b0;
    endtask

    // Wait for the ready strobe, counting edges since the caller drove the request.
    task automatic wait_ready(input int d, inout int lat);
        do begin
            tick();
            lat++;
        end while (!rdy_a[d] && lat < 20);
        if (!rdy_a[d]) check("timeout", 32'(rdy_a[d]), 32'h1);
    endtask

    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic e, output int lat);
        cs_a[d] = 1'b1; we_a[d] = w; oe_a[d] = ~w; addr_a[d] = a; wd_a[d] = wd;
        lat = 0;
        wait_ready(d, lat);
        rd = rd_a[d];
        e  = er_a[d];
        idle_bus(d);
        tick();
        check("ready_one_cycle", 32'(rdy_a[d]), 32'h0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    logic [31:0] fetch_exp [3];

    initial begin
        fetch_exp[0] = 32'h0A0A_0001;
        fetch_exp[1] = 32'h0B0B_0002;
        fetch_exp[2] = 32'h0C0C_0003;
        for (int d = 0; d < 2; d++) begin
            idle_bus(d); addr_a[d] = 32'h0; wd_a[d] = 32'h0;
        end
        rst = 1'b1;
        tick(); tick();
        check("rst_ready", 32'(rdy_a[0]), 32'h0);
        check("rst_err",   32'(er_a[0]),  32'h0);
        check("rst_rdata", rd_a[0],       32'h0);
        rst = 1'b0;
        tick();

        // Preload through the bus
        access(0, 1'b1, 32'h0, fetch_exp[0], rd, e, lat);
        check("wr_latency", lat, 3);
        check("wr_err", 32'(e), 32'h0);
        access(0, 1'b1, 32'h4, fetch_exp[1], rd, e, lat);
        access(0, 1'b1, 32'h8, fetch_exp[2], rd, e, lat);
        access(0, 1'b1, 32'h10, 32'hE3A0_1005, rd, e, lat);
        check("wr_rdata_untouched", rd, 32'h0);

        access(0, 1'b0, 32'h10, 32'h0, rd, e, lat);
        check("rd_latency", lat, 3);
        check("rd_data", rd, 32'hE3A0_1005);
        check("rd_err", 32'(e), 32'h0);

        access(0, 1'b1, 32'h20, 32'hCAFE_F00D, rd, e, lat);
        check("wr2_rdata_held", rd, 32'hE3A0_1005);
        access(0, 1'b0, 32'h20, 32'h0, rd, e, lat);
        check("rd_after_wr", rd, 32'hCAFE_F00D);

        // Continuous fetch with cs/oe held high
        cs_a[0] = 1'b1; oe_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            lat = 0;
            wait_ready(0, lat);
            check("fetch_gap", lat, (i == 0) ? 3 : 4);
            check("fetch_data", rd_a[0], fetch_exp[i]);
            addr_a[0] = 32'((i + 1) * 4);
        end
        idle_bus(0);
        tick();

        access(0, 1'b0, 32'h2, 32'h0, rd, e, lat);
        check("misalign_err", 32'(e), 32'h1);
        check("misalign_data", rd, 32'h0);

        access(0, 1'b1, 32'h1000, 32'hDEAD_BEEF, rd, e, lat);
        check("range_err", 32'(e), 32'h1);
        access(0, 1'b0, 32'h0, 32'h0, rd, e, lat);
        check("range_no_alias", rd, fetch_exp[0]);
        check("range_rd_err", 32'(e), 32'h0);

        // Dropping cs after accept still completes the access
        cs_a[0] = 1'b1; oe_a[0] = 1'b1; addr_a[0] = 32'h4;
        tick();
        idle_bus(0); addr_a[0] = 32'h20;
        lat = 1;
        wait_ready(0, lat);
        check("csdrop_latency", lat, 3);
        check("csdrop_data", rd_a[0], fetch_exp[1]);
        tick();

        // Reset during the wait of a write aborts it
        cs_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 32'h8; wd_a[0] = 32'h0000_1234;
        tick(); tick();
        rst = 1'b1;
        idle_bus(0);
        #1;
        check("rstwait_ready", 32'(rdy_a[0]), 32'h0);
        check("rstwait_rdata", rd_a[0], 32'h0);
        tick();
        check("rstwait_ready2", 32'(rdy_a[0]), 32'h0);
        rst = 1'b0;
        tick();
        access(0, 1'b0, 32'h8, 32'h0, rd, e, lat);
        check("rstwait_mem_kept", rd, fetch_exp[2]);

        // Reset during the response strobe forces it low at once
        cs_a[0] = 1'b1; oe_a[0] = 1'b1; addr_a[0] = 32'h2;
        lat = 0;
        wait_ready(0, lat);
        check("rstresp_err_before", 32'(er_a[0]), 32'h1);
        idle_bus(0);
        rst = 1'b1;
        #1;
        check("rstresp_ready", 32'(rdy_a[0]), 32'h0);
        check("rstresp_err", 32'(er_a[0]), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Zero-wait-state instance
        access(1, 1'b1, 32'h0, 32'h1111_1111, rd, e, lat);
        check("ws0_wr_latency", lat, 1);
        access(1, 1'b1, 32'h4, 32'h2222_2222, rd, e, lat);
        access(1, 1'b0, 32'h0, 32'h0, rd, e, lat);
        check("ws0_rd_latency", lat, 1);
        check("ws0_rd_data", rd, 32'h1111_1111);
        cs_a[1] = 1'b1; oe_a[1] = 1'b1; addr_a[1] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            lat = 0;
            wait_ready(1, lat);
            check("ws0_gap", lat, (i == 0) ? 1 : 2);
            check("ws0_fetch", rd_a[1], (i == 0) ? 32'h1111_1111 : 32'h2222_2222);
            addr_a[1] = 32'h4;
        end
        idle_bus(1);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
